// File: rtl/lfsr_tick_sequencer_pkg.sv
// Shared defaults and the LFSR step function for the DDS modulation tick sequencer.
package lfsr_pkg;

  localparam int         LFSR_W_DEF      = 5;
  localparam logic [4:0] LFSR_TAPS_DEF   = 5'b10100;
  localparam logic [4:0] LFSR_SEED_DEF   = 5'b00001;
  localparam int         SYNC_STAGES_DEF = 2;
  localparam int         LFSR_MAX_W      = 32;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_STEP,
    ACT_LOAD,
    ACT_GUARD
  } lfsr_act_e;

  // Callers zero-extend state/taps and truncate the result back to their width.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] state,
                                                     input logic [LFSR_MAX_W-1:0] taps);
    return (state << 1) | {{(LFSR_MAX_W-1){1'b0}}, ^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_tick_sequencer_if.sv
// Control and status bundle of the tick sequencer; slave side is the sequencer.
interface lfsr_tick_sequencer_if #(
  parameter int WIDTH = 5
);
  logic             tick_in;
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] lfsr_out;
  logic             mod_bit;
  logic             step_pulse;
  logic [WIDTH-1:0] step_count;
  logic             period_done;

  modport master (
    output tick_in, enable, load, seed_in,
    input  lfsr_out, mod_bit, step_pulse, step_count, period_done
  );

  modport slave (
    input  tick_in, enable, load, seed_in,
    output lfsr_out, mod_bit, step_pulse, step_count, period_done
  );
endinterface

// File: rtl/lfsr_tick_sequencer_edge_sync.sv
// Synchronises the divided clock into clk and emits a registered one-cycle rise strobe.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_pipe_q;
  logic                   prev_q;
  logic                   armed_q;
  logic                   rise_q;

  // vld_pipe_q marks when sync_q holds real samples rather than reset zeros, so a
  // tick_in that is already high at reset release cannot arm the detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      vld_pipe_q <= '0;
      prev_q     <= 1'b0;
      armed_q    <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], tick_i};
      vld_pipe_q <= {vld_pipe_q[SYNC_STAGES-2:0], 1'b1};
      prev_q     <= sync_q[SYNC_STAGES-1];
      armed_q    <= armed_q | (vld_pipe_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1]);
      rise_q     <= sync_q[SYNC_STAGES-1] & ~prev_q & armed_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/lfsr_tick_sequencer.sv
// Steps a Fibonacci LFSR once per divided-clock rising edge; LSB drives DDS modulation.
module lfsr_tick_sequencer
  import lfsr_pkg::*;
#(
  parameter int               WIDTH       = LFSR_W_DEF,
  parameter logic [WIDTH-1:0] TAPS        = LFSR_TAPS_DEF,
  parameter logic [WIDTH-1:0] SEED        = LFSR_SEED_DEF,
  parameter int               SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  lfsr_tick_sequencer_if.slave  bus
);

  localparam logic [WIDTH-1:0] CNT_MAX = {{(WIDTH-1){1'b1}}, 1'b0};

  logic             rise;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             done_q, done_d;
  lfsr_act_e        act;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk    (clk),
    .reset  (reset),
    .tick_i (bus.tick_in),
    .rise_o (rise)
  );

  assign lfsr_step = WIDTH'(lfsr_next(LFSR_MAX_W'(lfsr_q), LFSR_MAX_W'(TAPS)));

  // Load beats the lock-up guard, which beats a step; a dropped rise is not remembered.
  always_comb begin
    act = ACT_HOLD;
    if (bus.load)              act = ACT_LOAD;
    else if (lfsr_q == '0)     act = ACT_GUARD;
    else if (rise && bus.enable) act = ACT_STEP;
  end

  always_comb begin
    lfsr_d = lfsr_q;
    cnt_d  = cnt_q;
    step_d = 1'b0;
    done_d = 1'b0;
    case (act)
      ACT_LOAD: begin
        lfsr_d = (bus.seed_in == '0) ? SEED : bus.seed_in;
        cnt_d  = '0;
      end
      ACT_GUARD: lfsr_d = SEED;
      ACT_STEP: begin
        lfsr_d = lfsr_step;
        cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        step_d = 1'b1;
        done_d = (cnt_q == CNT_MAX);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= SEED;
      cnt_q  <= '0;
      step_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      done_q <= done_d;
    end
  end

  assign bus.lfsr_out    = lfsr_q;
  assign bus.mod_bit     = lfsr_q[0];
  assign bus.step_pulse  = step_q;
  assign bus.step_count  = cnt_q;
  assign bus.period_done = done_q;

endmodule

// File: tb/tb_lfsr_tick_sequencer.sv
// Directed bench for lfsr_tick_sequencer with hand-computed LFSR values (x^5+x^3+1).
module tb_lfsr_tick_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  lfsr_tick_sequencer_if #(.WIDTH(5)) bus();

  lfsr_tick_sequencer #(
    .WIDTH(5), .TAPS(5'b10100), .SEED(5'b00001), .SYNC_STAGES(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic tick_lvl);
    bus.tick_in = tick_lvl;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cycles(4);
  endtask

  // One tick_in period: 4 clk high, 6 clk low. Latency counted from the first sampling edge.
  task automatic tick_cycle(output int lat, output int npulse, output int npd,
                            output logic [4:0] lv, output logic [4:0] cv, output logic pd);
    lat = -1; npulse = 0; npd = 0; lv = '0; cv = '0; pd = 1'b0;
    bus.tick_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (bus.step_pulse) begin
        npulse++;
        if (lat < 0) begin
          lat = k - 1; lv = bus.lfsr_out; cv = bus.step_count; pd = bus.period_done;
        end
      end
      if (bus.period_done) npd++;
      if (k == 4) bus.tick_in = 1'b0;
    end
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    n_chk++; if (bus.lfsr_out !== 5'b00001) begin n_fail++; $display("FAIL reset_lfsr: got %b expected 00001", bus.lfsr_out); end
    n_chk++; if (bus.step_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.step_count); end
    n_chk++; if (bus.step_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b expected 0", bus.step_pulse); end
    n_chk++; if (bus.period_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.period_done); end
    n_chk++; if (bus.mod_bit !== 1'b1) begin n_fail++; $display("FAIL reset_modbit: got %b expected 1", bus.mod_bit); end
  endtask

  task automatic test_step_sequence;
    logic [4:0] exp_l [5] = '{5'b00010, 5'b00100, 5'b01001, 5'b10010, 5'b00101};
    logic [4:0] e, lv, cv;
    logic       pd;
    int         lat, np, npd;
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      e = exp_l[i];
      tick_cycle(lat, np, npd, lv, cv, pd);
      n_chk++; if (lv !== e) begin n_fail++; $display("FAIL seq_lfsr[%0d]: got %b expected %b", i, lv, e); end
      n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL seq_latency[%0d]: got %0d expected 3", i, lat); end
      n_chk++; if (np !== 1) begin n_fail++; $display("FAIL seq_pulses[%0d]: got %0d expected 1", i, np); end
      n_chk++; if (cv !== 5'(i + 1)) begin n_fail++; $display("FAIL seq_count[%0d]: got %0d expected %0d", i, cv, i + 1); end
      n_chk++; if (bus.mod_bit !== e[0]) begin n_fail++; $display("FAIL seq_modbit[%0d]: got %b expected %b", i, bus.mod_bit, e[0]); end
    end
  endtask

  task automatic test_period_wrap;
    logic [4:0] lv, cv;
    logic       pd;
    int         lat, np, npd;
    do_reset(1'b0);
    for (int i = 1; i <= 31; i++) begin
      tick_cycle(lat, np, npd, lv, cv, pd);
      n_chk++; if (cv !== 5'(i % 31)) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, cv, i % 31); end
      n_chk++; if (npd !== ((i == 31) ? 1 : 0)) begin n_fail++; $display("FAIL wrap_done_cnt[%0d]: got %0d expected %0d", i, npd, (i == 31) ? 1 : 0); end
      n_chk++; if (np !== 1) begin n_fail++; $display("FAIL wrap_pulses[%0d]: got %0d expected 1", i, np); end
    end
    n_chk++; if (pd !== 1'b1) begin n_fail++; $display("FAIL wrap_done_with_pulse: got %b expected 1", pd); end
    n_chk++; if (lv !== 5'b00001) begin n_fail++; $display("FAIL wrap_lfsr: got %b expected 00001", lv); end
  endtask

  task automatic test_high_at_reset;
    logic [4:0] lv, cv;
    logic       pd;
    int         lat, np, npd, seen;
    do_reset(1'b1);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.step_pulse) seen++;
    end
    n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL hi_reset_pulses: got %0d expected 0", seen); end
    n_chk++; if (bus.lfsr_out !== 5'b00001) begin n_fail++; $display("FAIL hi_reset_lfsr: got %b expected 00001", bus.lfsr_out); end
    bus.tick_in = 1'b0;
    cycles(5);
    tick_cycle(lat, np, npd, lv, cv, pd);
    n_chk++; if (lv !== 5'b00010) begin n_fail++; $display("FAIL hi_reset_step: got %b expected 00010", lv); end
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL hi_reset_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_load;
    logic [4:0] lv, cv;
    logic       pd;
    int         lat, np, npd, seen;
    do_reset(1'b0);
    tick_cycle(lat, np, npd, lv, cv, pd);
    tick_cycle(lat, np, npd, lv, cv, pd);
    seen = 0;
    bus.tick_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (bus.step_pulse) seen++;
      if (k == 4) begin
        n_chk++; if (bus.lfsr_out !== 5'b10110) begin n_fail++; $display("FAIL load_lfsr: got %b expected 10110", bus.lfsr_out); end
        n_chk++; if (bus.step_count !== 5'd0) begin n_fail++; $display("FAIL load_count: got %0d expected 0", bus.step_count); end
        bus.load = 1'b0;
        bus.tick_in = 1'b0;
      end
      if (k == 3) begin
        bus.load = 1'b1;
        bus.seed_in = 5'b10110;
      end
    end
    n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL load_drops_rise: got %0d pulses expected 0", seen); end
    tick_cycle(lat, np, npd, lv, cv, pd);
    n_chk++; if (lv !== 5'b01100) begin n_fail++; $display("FAIL load_next_step: got %b expected 01100", lv); end
    n_chk++; if (cv !== 5'd1) begin n_fail++; $display("FAIL load_next_count: got %0d expected 1", cv); end
    bus.load = 1'b1;
    bus.seed_in = 5'b00000;
    @(posedge clk); #1;
    bus.load = 1'b0;
    n_chk++; if (bus.lfsr_out !== 5'b00001) begin n_fail++; $display("FAIL load_zero_seed: got %b expected 00001", bus.lfsr_out); end
    n_chk++; if (bus.step_count !== 5'd0) begin n_fail++; $display("FAIL load_zero_count: got %0d expected 0", bus.step_count); end
  endtask

  task automatic test_enable;
    logic [4:0] lv, cv;
    logic       pd;
    int         lat, np, npd, total;
    do_reset(1'b0);
    tick_cycle(lat, np, npd, lv, cv, pd);
    bus.enable = 1'b0;
    total = 0;
    for (int i = 0; i < 3; i++) begin
      tick_cycle(lat, np, npd, lv, cv, pd);
      total += np;
    end
    n_chk++; if (total !== 0) begin n_fail++; $display("FAIL en_off_pulses: got %0d expected 0", total); end
    n_chk++; if (bus.lfsr_out !== 5'b00010) begin n_fail++; $display("FAIL en_off_hold: got %b expected 00010", bus.lfsr_out); end
    bus.enable = 1'b1;
    total = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (bus.step_pulse) total++;
    end
    n_chk++; if (total !== 0) begin n_fail++; $display("FAIL en_no_replay: got %0d expected 0", total); end
    n_chk++; if (bus.step_count !== 5'd1) begin n_fail++; $display("FAIL en_count_hold: got %0d expected 1", bus.step_count); end
    tick_cycle(lat, np, npd, lv, cv, pd);
    n_chk++; if (lv !== 5'b00100) begin n_fail++; $display("FAIL en_resume_step: got %b expected 00100", lv); end
    n_chk++; if (np !== 1) begin n_fail++; $display("FAIL en_resume_pulses: got %0d expected 1", np); end
  endtask

  task automatic test_async_reset;
    logic [4:0] lv, cv;
    logic       pd;
    int         lat, np, npd;
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) tick_cycle(lat, np, npd, lv, cv, pd);
    bus.tick_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
    end
    n_chk++; if (bus.step_pulse !== 1'b1) begin n_fail++; $display("FAIL arst_pre_pulse: got %b expected 1", bus.step_pulse); end
    n_chk++; if (bus.lfsr_out !== 5'b10010) begin n_fail++; $display("FAIL arst_pre_lfsr: got %b expected 10010", bus.lfsr_out); end
    #2 reset = 1'b1;
    #1;
    n_chk++; if (bus.lfsr_out !== 5'b00001) begin n_fail++; $display("FAIL arst_lfsr: got %b expected 00001", bus.lfsr_out); end
    n_chk++; if (bus.step_count !== 5'd0) begin n_fail++; $display("FAIL arst_count: got %0d expected 0", bus.step_count); end
    n_chk++; if (bus.step_pulse !== 1'b0) begin n_fail++; $display("FAIL arst_pulse: got %b expected 0", bus.step_pulse); end
    bus.tick_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cycles(4);
    tick_cycle(lat, np, npd, lv, cv, pd);
    n_chk++; if (lv !== 5'b00010) begin n_fail++; $display("FAIL arst_restart: got %b expected 00010", lv); end
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL arst_latency: got %0d expected 3", lat); end
    n_chk++; if (cv !== 5'd1) begin n_fail++; $display("FAIL arst_count_restart: got %0d expected 1", cv); end
  endtask

  initial begin
    reset       = 1'b1;
    bus.tick_in = 1'b0;
    bus.enable  = 1'b1;
    bus.load    = 1'b0;
    bus.seed_in = '0;
    test_reset;
    test_step_sequence;
    test_period_wrap;
    test_high_at_reset;
    test_load;
    test_enable;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
